// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default sizing for the program sequencer
package seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
    localparam int SEQ_D        = 12;
    localparam int SEQ_NPROG    = 4;
    localparam int SEQ_END_ADDR = 256;
    localparam int SEQ_MAX_CYC  = 4096;
endpackage

// File: rtl/prog_lut.sv
// prog_lut: combinational program-slot to start-address table, slot k starts at k*64
module prog_lut
    import seq_pkg::*;
#(
    parameter int D     = SEQ_D,
    parameter int NPROG = SEQ_NPROG
) (
    input  logic [$clog2(NPROG)-1:0] slot,
    output logic [D-1:0]             start
);
    logic [D-1:0] lut [NPROG];
    for (genvar k = 0; k < NPROG; k++) begin : g_lut
        assign lut[k] = D'(k * 64);
    end
    assign start = lut[slot];
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: PC, run handshake, jumps/branches, halt/end detection; optional watchdog via SEQ_WATCHDOG_EN
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int D        = SEQ_D,
    parameter int NPROG    = SEQ_NPROG,
    parameter int END_ADDR = SEQ_END_ADDR,
    parameter int MAX_CYC  = SEQ_MAX_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic [$clog2(NPROG)-1:0]   prog_sel,
    input  logic                       stall,
    input  logic                       halt,
    input  logic                       jump_en,
    input  logic                       branch_en,
    input  logic [D-1:0]               target,
    output logic [D-1:0]               prog_ctr,
    output logic [D-1:0]               link_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [$clog2(MAX_CYC):0]   cyc_cnt
);
    localparam int CW = $clog2(MAX_CYC) + 1;

    seq_state_e   state, state_d;
    logic [D-1:0] pc_d, link_d, start;
    logic [CW-1:0] cnt_d;
    logic         at_end;

    prog_lut #(.D(D), .NPROG(NPROG)) u_lut (
        .slot  (prog_sel),
        .start (start)
    );

    assign at_end = halt || prog_ctr == D'(END_ADDR);
    assign busy   = state == RUN;
    assign done   = state == DONE;

`ifdef SEQ_WATCHDOG_EN
    logic to_d;
`else
    assign timeout = 1'b0;
`endif

    // next-state and next-PC selection; halt/end beats the watchdog on the same edge
    always_comb begin
        state_d = state;
        pc_d    = prog_ctr;
        link_d  = link_addr;
        cnt_d   = cyc_cnt;
`ifdef SEQ_WATCHDOG_EN
        to_d    = timeout;
`endif
        case (state)
            IDLE: if (req) begin
                state_d = RUN;
                pc_d    = start;
                cnt_d   = '0;
`ifdef SEQ_WATCHDOG_EN
                to_d    = 1'b0;
`endif
            end
            RUN: begin
                cnt_d = &cyc_cnt ? cyc_cnt : cyc_cnt + 1'b1;
                if (!stall && at_end) state_d = DONE;
                else begin
                    if (!stall) pc_d = jump_en ? target : branch_en ? prog_ctr + target : prog_ctr + 1'b1;
                    if (!stall && jump_en) link_d = prog_ctr + 1'b1;
`ifdef SEQ_WATCHDOG_EN
                    if (cyc_cnt == CW'(MAX_CYC - 1)) begin
                        state_d = DONE;
                        to_d    = 1'b1;
                        pc_d    = prog_ctr;
                        link_d  = link_addr;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers, cleared asynchronously so a mid-run reset gives no done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            link_addr <= '0;
            cyc_cnt   <= '0;
`ifdef SEQ_WATCHDOG_EN
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            prog_ctr  <= pc_d;
            link_addr <= link_d;
            cyc_cnt   <= cnt_d;
`ifdef SEQ_WATCHDOG_EN
            timeout   <= to_d;
`endif
        end
    end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program-flow sequencer for the core: owns the program counter, the req/done run handshake, program-slot selection, absolute jumps with link capture, relative branches, halt/end-of-program detection and an optional cycle watchdog. It sits in the fetch stage between the control decoder (branch/jump/halt) and the instruction ROM, and supersedes the bare PC plus the `done = prog_ctr == 256` compare in the top level.

## Interface
Parameters:
- D, 12, program counter width.
- NPROG, 4, number of selectable program slots; start addresses come from `prog_lut`.
- END_ADDR, 256, PC value that terminates a run.
- MAX_CYC, 4096, watchdog limit in RUN cycles; used only with `SEQ_WATCHDOG_EN`.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- req  in  1  level run request, sampled only in IDLE.
- prog_sel  in  $clog2(NPROG)  program slot, sampled with req.
- stall  in  1  freezes PC, link and flow decisions for the cycle.
- halt  in  1  decoded halt instruction at current PC.
- jump_en  in  1  absolute jump to target, with link capture.
- branch_en  in  1  relative branch by target.
- target  in  D  jump address or two's-complement branch offset.
- prog_ctr  out  D  current PC to instr ROM.
- link_addr  out  D  return address captured on jump.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.
- timeout  out  1  last run ended by watchdog.
- cyc_cnt  out  $clog2(MAX_CYC)+1  RUN cycles elapsed in current or last run.

## Operation
- States: IDLE, RUN, DONE. All outputs registered or Moore-decoded from state.
- Reset values: state IDLE; prog_ctr 0, link_addr 0, busy 0, done 0, timeout 0, cyc_cnt 0.
- IDLE, req=1: prog_ctr <= start[prog_sel], cyc_cnt <= 0, timeout <= 0, go RUN. req=0: hold.
- RUN, stall=0, next-PC priority: halt or prog_ctr==END_ADDR -> go DONE, PC held; else jump_en -> PC <= target, link_addr <= PC+1; else branch_en -> PC <= PC+target; else PC <= PC+1.
- RUN, stall=1: PC, link and state held; halt/jump/branch/end ignored; cyc_cnt still counts.
- All PC arithmetic is modulo 2^D; wraps silently. target is D-bit signed for branches.
- DONE: done=1, busy=0, PC and link held; next edge -> IDLE unconditionally. If req is still high, a new run starts on the following IDLE edge.
- Reset mid-run: immediate return to reset values, no done pulse.

## Timing
- Start latency: req high at edge N in IDLE -> busy=1 and prog_ctr=start from N onward.
- Control inputs relate to the current prog_ctr; effects are visible after the next edge.
- halt/end at edge M -> done high for exactly cycle M..M+1, IDLE at M+1.
- cyc_cnt increments each RUN edge and saturates; it holds through DONE and IDLE until the next start.
- Watchdog: RUN edge with cyc_cnt == MAX_CYC-1 -> DONE, timeout <= 1. halt or end on the same edge wins, and timeout stays 0.

## Configuration
- `SEQ_WATCHDOG_EN` defined: watchdog as above.
- Undefined: no watchdog logic; timeout tied 0; a run ends only on halt, END_ADDR or reset; cyc_cnt still counts and saturates.

## Structure
- Package `seq_pkg`: state enum (IDLE, RUN, DONE), default D, NPROG, END_ADDR, MAX_CYC constants.
- Sub-module `prog_lut`: combinational slot->start-address table of NPROG entries; slot 0 = 0, slot k = k·64 by default.

## Test plan
- Reset, then req=1, prog_sel=2 -> prog_ctr=0x080 next cycle, busy=1, then 0x081, 0x082.
- jump_en, target=0x123 at PC 0x085 -> PC=0x123, link_addr=0x086. branch_en, target=0xFFE at PC 0x050 -> PC=0x04E. Increment at 0xFFF -> 0x000.
- halt with jump_en both high at PC 0x060 -> PC stays 0x060, done one cycle, busy 0, timeout 0. Run reaching PC 0x100 -> same.
- MAX_CYC=16 with jump-to-self loop, macro defined -> done after 16 RUN cycles, timeout=1, cyc_cnt=16. Macro undefined -> never done.
- stall held 3 cycles during RUN with halt high -> PC frozen, no done, cyc_cnt +3. halt honoured after stall drops.
- reset low mid-run at PC 0x0A3 -> outputs zero immediately, IDLE. req still high after reset release -> new run from start[prog_sel].
